// File: rtl/axis_rx_fifo.sv
// AXI-Stream slave receiver that buffers beats in a first-word-fall-through FIFO
// and exposes them on a pop interface. It also keeps beat and packet statistics
// and a sticky flag for packets longer than MAX_PKT_BEATS.
module axis_rx_fifo #(
  parameter int unsigned DATA_W        = 64,
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned MAX_PKT_BEATS = 256,
  parameter int unsigned CNT_W         = 32
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     s_tvalid,
  output logic                     s_tready,
  input  logic                     s_tlast,
  input  logic [DATA_W-1:0]        s_tdata,
  input  logic                     rd_en,
  output logic                     rd_valid,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_last,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         pkt_count,
  output logic [CNT_W-1:0]         beat_count,
  output logic                     err_oversize,
  input  logic                     clr_stats
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned PW    = AW + 1;
  // Holds 0..MAX_PKT_BEATS+1; the top value marks "already past the limit".
  localparam int unsigned PKT_W = $clog2(MAX_PKT_BEATS + 2);

  logic [DATA_W:0]    r_mem [DEPTH];
  logic [PW-1:0]      r_wr_ptr;
  logic [PW-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]   r_pkt_count;
  logic [CNT_W-1:0]   r_beat_count;
  logic               r_err_oversize;
  logic [PKT_W-1:0]   r_pkt_beats;

  logic [PW-1:0]      w_level;
  logic               w_empty;
  logic               w_full;
  logic               w_accept;
  logic               w_pop;
  logic               w_oversize;
  logic [DATA_W:0]    w_head;

  // Occupancy and flags from the extra-MSB pointer pair.
  assign w_level  = r_wr_ptr - r_rd_ptr;
  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (r_wr_ptr == {~r_rd_ptr[PW-1], r_rd_ptr[AW-1:0]});

  // Ready depends only on registered state and reset, never on tvalid.
  assign s_tready = !areset && !w_full;
  assign w_accept = s_tvalid && s_tready;
  assign w_pop    = rd_en && !w_empty;

  // The (MAX_PKT_BEATS+1)-th beat of a packet trips the oversize flag.
  assign w_oversize = w_accept && (r_pkt_beats == PKT_W'(MAX_PKT_BEATS));

  // FWFT head presentation straight from storage.
  assign w_head   = r_mem[r_rd_ptr[AW-1:0]];
  assign rd_valid = !w_empty;
  assign rd_data  = w_head[DATA_W-1:0];
  assign rd_last  = w_head[DATA_W];
  assign level    = w_level;

  assign pkt_count    = r_pkt_count;
  assign beat_count   = r_beat_count;
  assign err_oversize = r_err_oversize;

  // Storage write; contents need no reset since pointers define validity.
  always_ff @(posedge aclk) begin
    if (w_accept) begin
      r_mem[r_wr_ptr[AW-1:0]] <= {s_tlast, s_tdata};
    end
  end

  // Write and read pointer advance.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
    end
  end

  // Saturating statistics and sticky oversize flag; clear wins over updates.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_pkt_count    <= '0;
      r_beat_count   <= '0;
      r_err_oversize <= 1'b0;
    end else if (clr_stats) begin
      r_pkt_count    <= '0;
      r_beat_count   <= '0;
      r_err_oversize <= 1'b0;
    end else begin
      if (w_accept && (r_beat_count != '1)) begin
        r_beat_count <= r_beat_count + CNT_W'(1);
      end
      if (w_accept && s_tlast && (r_pkt_count != '1)) begin
        r_pkt_count <= r_pkt_count + CNT_W'(1);
      end
      if (w_oversize) begin
        r_err_oversize <= 1'b1;
      end
    end
  end

  // Beats accepted so far in the current packet, parked once past the limit.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_pkt_beats <= '0;
    end else if (w_accept) begin
      if (s_tlast) begin
        r_pkt_beats <= '0;
      end else if (r_pkt_beats != PKT_W'(MAX_PKT_BEATS + 1)) begin
        r_pkt_beats <= r_pkt_beats + PKT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_axis_rx_fifo.sv
// Randomized and directed bench for axis_rx_fifo against a queue-based model.
module tb_axis_rx_fifo;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned MAXPB  = 4;
  localparam int unsigned CNT_W  = 8;
  localparam int          CMAX   = (1 << CNT_W) - 1;

  logic                   aclk;
  logic                   areset;
  logic                   s_tvalid;
  logic                   s_tready;
  logic                   s_tlast;
  logic [DATA_W-1:0]      s_tdata;
  logic                   rd_en;
  logic                   rd_valid;
  logic [DATA_W-1:0]      rd_data;
  logic                   rd_last;
  logic [$clog2(DEPTH):0] level;
  logic [CNT_W-1:0]       pkt_count;
  logic [CNT_W-1:0]       beat_count;
  logic                   err_oversize;
  logic                   clr_stats;

  axis_rx_fifo #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .MAX_PKT_BEATS(MAXPB), .CNT_W(CNT_W)
  ) dut (
    .aclk(aclk), .areset(areset),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast), .s_tdata(s_tdata),
    .rd_en(rd_en), .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
    .level(level), .pkt_count(pkt_count), .beat_count(beat_count),
    .err_oversize(err_oversize), .clr_stats(clr_stats)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: FIFO as a queue of {last, data}, statistics as integers.
  logic [DATA_W:0] mq[$];
  int  m_pkt   = 0;
  int  m_beat  = 0;
  int  m_inpkt = 0;
  bit  m_err   = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive at the falling edge, check, advance the model, move on.
  task automatic step(input logic v, input logic l, input logic [DATA_W-1:0] d,
                      input logic re, input logic clr, input logic rst);
    bit acc;
    bit pop;
    s_tvalid  = v;
    s_tlast   = l;
    s_tdata   = d;
    rd_en     = re;
    clr_stats = clr;
    areset    = rst;
    #1;
    check("s_tready", 64'(s_tready), 64'(!rst && (mq.size() < DEPTH)));
    check("rd_valid", 64'(rd_valid), 64'(mq.size() != 0));
    check("level", 64'(level), 64'(mq.size()));
    if (mq.size() != 0) begin
      check("rd_data", rd_data, mq[0][DATA_W-1:0]);
      check("rd_last", 64'(rd_last), 64'(mq[0][DATA_W]));
    end
    check("pkt_count", 64'(pkt_count), 64'(m_pkt));
    check("beat_count", 64'(beat_count), 64'(m_beat));
    check("err_oversize", 64'(err_oversize), 64'(m_err));

    if (rst) begin
      mq.delete();
      m_pkt = 0; m_beat = 0; m_inpkt = 0; m_err = 1'b0;
    end else begin
      acc = v && (mq.size() < DEPTH);
      pop = re && (mq.size() != 0);
      if (pop) void'(mq.pop_front());
      if (acc) mq.push_back({l, d});
      if (clr) begin
        m_pkt = 0; m_beat = 0; m_err = 1'b0;
      end else if (acc) begin
        if (m_beat < CMAX) m_beat++;
        if (l && m_pkt < CMAX) m_pkt++;
        if (m_inpkt + 1 == MAXPB + 1) m_err = 1'b1;
      end
      if (acc) m_inpkt = l ? 0 : m_inpkt + 1;
    end
    @(negedge aclk);
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * DEPTH && mq.size() != 0; i++) step(0, 0, '0, 1, 0, 0);
    check("drained_level", 64'(level), 64'(0));
  endtask

  initial begin
    areset = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0;
    rd_en = 1'b0; clr_stats = 1'b0;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    step(0, 0, '0, 0, 0, 1);

    // Three-beat packet, then pop it out.
    step(1, 0, 64'hA1, 0, 0, 0);
    step(1, 0, 64'hA2, 0, 0, 0);
    step(1, 1, 64'hA3, 0, 0, 0);
    check("tp1_level", 64'(level), 64'(3));
    check("tp1_head", rd_data, 64'hA1);
    check("tp1_last", 64'(rd_last), 64'(0));
    check("tp1_pkts", 64'(pkt_count), 64'(1));
    check("tp1_beats", 64'(beat_count), 64'(3));
    step(0, 0, '0, 1, 0, 0);
    check("tp1_head2", rd_data, 64'hA2);
    step(0, 0, '0, 1, 0, 0);
    check("tp1_head3", rd_data, 64'hA3);
    check("tp1_last3", 64'(rd_last), 64'(1));
    step(0, 0, '0, 1, 0, 0);
    check("tp1_empty", 64'(rd_valid), 64'(0));

    // Fill to full, hold the 17th beat, pop once, then it goes in.
    for (int i = 0; i < DEPTH; i++) step(1, 0, 64'(i + 1), 0, 0, 0);
    check("full_level", 64'(level), 64'(DEPTH));
    check("full_ready", 64'(s_tready), 64'(0));
    step(1, 1, 64'd17, 0, 0, 0);
    step(1, 1, 64'd17, 1, 0, 0);
    check("full_ready_back", 64'(s_tready), 64'(1));
    step(1, 1, 64'd17, 0, 0, 0);
    check("full_refill", 64'(level), 64'(DEPTH));
    drain();

    // Streaming with simultaneous push and pop.
    step(0, 0, '0, 0, 1, 0);
    for (int i = 0; i < 100; i++) begin
      step(1, 0, 64'(1000 + i), 1, 0, 0);
      check("stream_level_le1", 64'(level <= 1), 64'(1));
    end
    check("stream_beats", 64'(beat_count), 64'(100));
    drain();

    // Oversize: 4 beats legal, 5 beats flagged, clear keeps FIFO.
    step(0, 0, '0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(1, i == 3, 64'(200 + i), 0, 0, 0);
    check("ovs_legal", 64'(err_oversize), 64'(0));
    drain();
    for (int i = 0; i < 5; i++) step(1, i == 4, 64'(300 + i), 0, 0, 0);
    check("ovs_flag", 64'(err_oversize), 64'(1));
    check("ovs_level", 64'(level), 64'(5));
    check("ovs_pkts", 64'(pkt_count), 64'(2));
    step(0, 0, '0, 0, 1, 0);
    check("clr_flag", 64'(err_oversize), 64'(0));
    check("clr_beats", 64'(beat_count), 64'(0));
    check("clr_level", 64'(level), 64'(5));
    drain();

    // Reset mid-packet, then a fresh packet.
    step(1, 0, 64'hB1, 0, 0, 0);
    step(1, 0, 64'hB2, 0, 0, 0);
    step(1, 0, 64'hB3, 0, 0, 1);
    step(0, 0, '0, 0, 0, 1);
    check("rst_level", 64'(level), 64'(0));
    for (int i = 0; i < 3; i++) step(1, i == 2, 64'(64'hC0 + i), 0, 0, 0);
    check("rst_pkts", 64'(pkt_count), 64'(1));
    check("rst_beats", 64'(beat_count), 64'(3));
    check("rst_noerr", 64'(err_oversize), 64'(0));
    drain();

    // Pop while empty, then push coinciding with clear.
    step(0, 0, '0, 1, 0, 0);
    check("empty_pop", 64'(level), 64'(0));
    step(1, 1, 64'hD1, 0, 1, 0);
    check("clr_push_level", 64'(level), 64'(1));
    check("clr_push_beats", 64'(beat_count), 64'(0));
    check("clr_push_data", rd_data, 64'hD1);
    drain();

    // Counter saturation.
    step(0, 0, '0, 0, 1, 0);
    for (int i = 0; i < 300; i++) step(1, 1, 64'(i), 1, 0, 0);
    check("sat_beats", 64'(beat_count), 64'(CMAX));
    check("sat_pkts", 64'(pkt_count), 64'(CMAX));
    drain();

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      step(($urandom % 4) != 0, ($urandom % 4) == 0,
           {32'($urandom), 32'($urandom)},
           ($urandom % 3) != 0, ($urandom % 40) == 0, ($urandom % 150) == 0);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
